// File: rtl/eth_rx_noc_out.sv
// eth_rx_noc_out: turns one received Ethernet frame into a NoC message
// (header flit, metadata flit, payload flits) with length enforcement.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   mac_hdr_val/rdy     frame header handshake (eth hdr, len, timestamp, dst)
//   mac_data_val/rdy    payload beat handshake (512b, last, padbytes)
//   noc_out_val/rdy     NoC flit handshake, noc_out_data 512b flit
//   err_len_mismatch    one-cycle pulse when payload_len and last disagree
//
// Header flit layout, MSB first:
//   dst_x[8] dst_y[8] src_x[8] src_y[8] msg_len[16] msg_type[8]
//   timestamp[64], remaining 392 bits zero.
// Metadata flit: eth_dst[48] eth_src[48] eth_type[16] payload_size[16],
//   remaining 384 bits zero.
module eth_rx_noc_out #(
  parameter int SRC_X = 0,
  parameter int SRC_Y = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mac_hdr_val,
  output logic         mac_hdr_rdy,
  input  logic [111:0] mac_eth_hdr,
  input  logic [15:0]  mac_payload_len,
  input  logic [63:0]  mac_timestamp,
  input  logic [7:0]   mac_dst_x,
  input  logic [7:0]   mac_dst_y,
  input  logic         mac_data_val,
  output logic         mac_data_rdy,
  input  logic [511:0] mac_data,
  input  logic         mac_data_last,
  input  logic [5:0]   mac_data_padbytes,
  output logic         noc_out_val,
  input  logic         noc_out_rdy,
  output logic [511:0] noc_out_data,
  output logic         err_len_mismatch
);

  localparam logic [7:0] MSG_ETH_RX = 8'h21;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_META,
    S_DATA,
    S_PAD,
    S_DRAIN
  } state_t;

  state_t         r_state;
  logic [511:0]   r_flit;
  logic [111:0]   r_eth_hdr;
  logic [15:0]    r_plen;
  logic [10:0]    r_remain;
  logic           r_err;

  logic [16:0]    w_sum;
  logic [10:0]    w_dflits;
  logic [15:0]    w_msg_len;
  logic [511:0]   w_hdr_flit;
  logic           w_final;
  logic [5:0]     w_mod;
  logic [511:0]   w_masked;
  logic           w_unused;

  // 17-bit sum so a 65535-byte payload still yields 1024 flits
  assign w_sum     = {1'b0, mac_payload_len} + 17'd63;
  assign w_dflits  = w_sum[16:6];
  assign w_msg_len = {5'd0, w_dflits} + 16'd1;

  assign w_hdr_flit = {
    mac_dst_x, mac_dst_y, 8'(SRC_X), 8'(SRC_Y),
    w_msg_len, MSG_ETH_RX, mac_timestamp, 392'd0
  };

  assign w_final = (r_remain == 11'd1);
  assign w_mod   = r_plen[5:0];

  // padbytes is informational only; length control uses payload_len
  assign w_unused = ^{mac_data_padbytes, w_sum[5:0]};

  // Trailing bytes of the last counted flit beyond payload_len are zeroed
  always_comb begin
    w_masked = mac_data;
    if (w_final && w_mod != 6'd0) begin
      for (int i = 0; i < 64; i++) begin
        if (6'(i) >= w_mod)
          w_masked[511-8*i -: 8] = 8'h00;
      end
    end
  end

  assign mac_hdr_rdy      = (r_state == S_IDLE);
  assign err_len_mismatch = r_err;

  always_comb begin
    mac_data_rdy = 1'b0;
    noc_out_val  = 1'b0;
    noc_out_data = '0;
    case (r_state)
      S_HDR, S_META, S_PAD: begin
        noc_out_val  = 1'b1;
        noc_out_data = r_flit;
      end
      S_DATA: begin
        noc_out_val  = mac_data_val;
        mac_data_rdy = noc_out_rdy;
        noc_out_data = w_masked;
      end
      S_DRAIN: mac_data_rdy = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_flit    <= '0;
      r_eth_hdr <= '0;
      r_plen    <= '0;
      r_remain  <= '0;
      r_err     <= 1'b0;
    end else begin
      r_err <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (mac_hdr_val) begin
            r_eth_hdr <= mac_eth_hdr;
            r_plen    <= mac_payload_len;
            r_remain  <= w_dflits;
            r_flit    <= w_hdr_flit;
            r_state   <= S_HDR;
          end
        end
        S_HDR: begin
          if (noc_out_rdy) begin
            r_flit  <= {r_eth_hdr, r_plen, 384'd0};
            r_state <= S_META;
          end
        end
        S_META: begin
          if (noc_out_rdy) begin
            // zeroed here so PAD flits come straight from r_flit
            r_flit  <= '0;
            r_state <= (r_remain == 11'd0) ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (mac_data_val && noc_out_rdy) begin
            r_remain <= r_remain - 11'd1;
            if (w_final) begin
              r_err   <= ~mac_data_last;
              r_state <= mac_data_last ? S_IDLE : S_DRAIN;
            end else if (mac_data_last) begin
              r_err   <= 1'b1;
              r_state <= S_PAD;
            end
          end
        end
        S_PAD: begin
          if (noc_out_rdy) begin
            r_remain <= r_remain - 11'd1;
            if (w_final)
              r_state <= S_IDLE;
          end
        end
        S_DRAIN: begin
          if (mac_data_val && mac_data_last)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_rx_noc_out.sv
// tb_eth_rx_noc_out: table of frames run through the block with
// flit capture, plus a hand sequence for reset in the middle of a frame.
module tb_eth_rx_noc_out;

  localparam logic [7:0] SX     = 8'd3;
  localparam logic [7:0] SY     = 8'd5;
  localparam logic [7:0] ETH_RX = 8'h21;

  logic         clk = 1'b0;
  logic         rst;
  logic         mac_hdr_val;
  logic         mac_hdr_rdy;
  logic [111:0] mac_eth_hdr;
  logic [15:0]  mac_payload_len;
  logic [63:0]  mac_timestamp;
  logic [7:0]   mac_dst_x;
  logic [7:0]   mac_dst_y;
  logic         mac_data_val;
  logic         mac_data_rdy;
  logic [511:0] mac_data;
  logic         mac_data_last;
  logic [5:0]   mac_data_padbytes;
  logic         noc_out_val;
  logic         noc_out_rdy;
  logic [511:0] noc_out_data;
  logic         err_len_mismatch;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  eth_rx_noc_out #(.SRC_X(3), .SRC_Y(5)) dut (
    .clk               (clk),
    .rst               (rst),
    .mac_hdr_val       (mac_hdr_val),
    .mac_hdr_rdy       (mac_hdr_rdy),
    .mac_eth_hdr       (mac_eth_hdr),
    .mac_payload_len   (mac_payload_len),
    .mac_timestamp     (mac_timestamp),
    .mac_dst_x         (mac_dst_x),
    .mac_dst_y         (mac_dst_y),
    .mac_data_val      (mac_data_val),
    .mac_data_rdy      (mac_data_rdy),
    .mac_data          (mac_data),
    .mac_data_last     (mac_data_last),
    .mac_data_padbytes (mac_data_padbytes),
    .noc_out_val       (noc_out_val),
    .noc_out_rdy       (noc_out_rdy),
    .noc_out_data      (noc_out_data),
    .err_len_mismatch  (err_len_mismatch)
  );

  typedef struct {
    int plen;
    int nbeats;
    int exp_msg_len;
    int exp_err;
    bit rnd;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name,
                     input logic [511:0] act,
                     input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] beat(input int seed, input int k);
    logic [511:0] d;
    for (int b = 0; b < 64; b++)
      d[511-8*b -: 8] = 8'(seed * 16 + k * 64 + b + 1);
    return d;
  endfunction

  function automatic logic [511:0] keep_bytes(input logic [511:0] d,
                                              input int nvalid);
    logic [511:0] r;
    r = d;
    for (int b = nvalid; b < 64; b++)
      r[511-8*b -: 8] = 8'h00;
    return r;
  endfunction

  function automatic logic [511:0] hdr_flit(input logic [7:0] dx,
                                            input logic [7:0] dy,
                                            input int ml,
                                            input logic [63:0] ts);
    return {dx, dy, SX, SY, 16'(ml), ETH_RX, ts, 392'd0};
  endfunction

  task automatic run_frame(input vec_t v, input int seed);
    logic [511:0] cap[$];
    logic [511:0] prev_data;
    logic [511:0] exp;
    logic [111:0] eh;
    logic [63:0]  ts;
    logic [7:0]   dx, dy;
    int  nb_sent = 0;
    int  errs = 0;
    int  cyc = 0;
    int  dflits;
    int  nvalid;
    bit  accepted = 0;
    bit  done = 0;
    bit  rdy_seen = 0;
    bit  pend = 0;
    bit  prev_stall = 0;
    bit  hdr_xfer, dat_xfer;

    eh = {48'h0200_0000_0000 + 48'(seed),
          48'h0400_0000_0000 + 48'(seed), 16'h0800};
    ts = 64'h1122_3344_5566_0000 + 64'(seed);
    dx = 8'(seed + 1);
    dy = 8'(seed + 2);
    dflits = v.exp_msg_len - 1;

    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      mac_hdr_val     = !accepted;
      mac_eth_hdr     = eh;
      mac_payload_len = 16'(v.plen);
      mac_timestamp   = ts;
      mac_dst_x       = dx;
      mac_dst_y       = dy;
      if (nb_sent >= v.nbeats)
        pend = 0;
      else if (!pend)
        pend = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      mac_data_val      = pend;
      mac_data          = beat(seed, nb_sent);
      mac_data_last     = (nb_sent == v.nbeats - 1);
      mac_data_padbytes = 6'(nb_sent * 5 + 3);
      noc_out_rdy = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (prev_stall) begin
        checks++;
        if (!noc_out_val || noc_out_data !== prev_data) begin
          failures++;
          $display("FAIL stall_hold seed=%0d actual val=%b data=%h",
                   seed, noc_out_val, noc_out_data);
        end
      end
      prev_stall = noc_out_val && !noc_out_rdy;
      prev_data  = noc_out_data;
      if (noc_out_val && noc_out_rdy)
        cap.push_back(noc_out_data);
      if (err_len_mismatch)
        errs++;
      if (mac_data_rdy)
        rdy_seen = 1;
      if (accepted && mac_hdr_rdy)
        done = 1;
      hdr_xfer = mac_hdr_val && mac_hdr_rdy;
      dat_xfer = mac_data_val && mac_data_rdy;
      @(posedge clk);
      if (hdr_xfer)
        accepted = 1;
      if (dat_xfer) begin
        nb_sent++;
        pend = 0;
      end
    end
    mac_hdr_val  = 0;
    mac_data_val = 0;

    chk($sformatf("done_%0d", seed), 512'(done), 512'd1);
    chk($sformatf("nflits_%0d", seed), 512'(cap.size()),
        512'(v.exp_msg_len + 1));
    chk($sformatf("errs_%0d", seed), 512'(errs), 512'(v.exp_err));
    chk($sformatf("beats_%0d", seed), 512'(nb_sent), 512'(v.nbeats));
    if (cap.size() > 0)
      chk($sformatf("hdr_%0d", seed), cap[0],
          hdr_flit(dx, dy, v.exp_msg_len, ts));
    if (cap.size() > 1)
      chk($sformatf("meta_%0d", seed), cap[1],
          {eh, 16'(v.plen), 384'd0});
    nvalid = (v.plen % 64 == 0) ? 64 : v.plen % 64;
    for (int k = 0; k < dflits; k++) begin
      if (k < v.nbeats) begin
        exp = beat(seed, k);
        if (k == dflits - 1)
          exp = keep_bytes(exp, nvalid);
      end else begin
        exp = '0;
      end
      if (cap.size() > k + 2)
        chk($sformatf("data_%0d_%0d", seed, k), cap[k+2], exp);
    end
    if (dflits == 0)
      chk($sformatf("no_data_rdy_%0d", seed), 512'(rdy_seen), 512'd0);
  endtask

  task automatic reset_seq();
    logic [111:0] eh;
    eh = {48'hAABB_CCDD_EEFF, 48'h1122_3344_5566, 16'h86DD};
    @(negedge clk);
    noc_out_rdy     = 1;
    mac_hdr_val     = 1;
    mac_payload_len = 16'd192;
    mac_eth_hdr     = eh;
    mac_dst_x       = 8'd7;
    mac_dst_y       = 8'd9;
    mac_timestamp   = 64'h55;
    mac_data_val    = 0;
    #1 chk("rs_hdr_rdy", 512'(mac_hdr_rdy), 512'd1);
    @(negedge clk);
    mac_hdr_val = 0;
    #1 chk("rs_hdr_flit", noc_out_data, hdr_flit(8'd7, 8'd9, 4, 64'h55));
    @(negedge clk);
    #1 chk("rs_meta", noc_out_data, {eh, 16'd192, 384'd0});
    @(negedge clk);
    mac_data_val  = 1;
    mac_data      = beat(7, 0);
    mac_data_last = 0;
    #1;
    chk("rs_data0", noc_out_data, beat(7, 0));
    chk("rs_data0_rdy", 512'(mac_data_rdy), 512'd1);
    @(negedge clk);
    rst          = 1;
    mac_data_val = 0;
    @(negedge clk);
    rst = 0;
    #1;
    chk("rs_idle_hdr_rdy", 512'(mac_hdr_rdy), 512'd1);
    chk("rs_idle_val", 512'(noc_out_val), 512'd0);
    chk("rs_idle_data", noc_out_data, 512'd0);
    chk("rs_idle_data_rdy", 512'(mac_data_rdy), 512'd0);
  endtask

  initial begin
    rst               = 1;
    mac_hdr_val       = 0;
    mac_eth_hdr       = '0;
    mac_payload_len   = '0;
    mac_timestamp     = '0;
    mac_dst_x         = '0;
    mac_dst_y         = '0;
    mac_data_val      = 0;
    mac_data          = '0;
    mac_data_last     = 0;
    mac_data_padbytes = '0;
    noc_out_rdy       = 0;

    vecs[0] = '{130, 3, 4, 0, 0};
    vecs[1] = '{0,   0, 1, 0, 0};
    vecs[2] = '{128, 1, 3, 1, 0};
    vecs[3] = '{64,  3, 2, 1, 0};
    vecs[4] = '{1,   1, 2, 0, 0};
    vecs[5] = '{192, 3, 4, 0, 1};
    vecs[6] = '{100, 2, 3, 0, 1};
    vecs[7] = '{200, 2, 5, 1, 1};

    repeat (3) @(negedge clk);
    rst = 0;
    #1;
    chk("rst_hdr_rdy", 512'(mac_hdr_rdy), 512'd1);
    chk("rst_data_rdy", 512'(mac_data_rdy), 512'd0);
    chk("rst_val", 512'(noc_out_val), 512'd0);
    chk("rst_data", noc_out_data, 512'd0);
    chk("rst_err", 512'(err_len_mismatch), 512'd0);

    for (int i = 0; i < 8; i++)
      run_frame(vecs[i], i + 1);

    reset_seq();
    run_frame(vecs[0], 9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
